instruction_fetch_stage: RTL and testbench
==========================================

// Module: instruction_fetch_stage
// PURPOSE
//  PC register, next-PC select and IF/ID pipeline register of the MIPS core.
//  Drives the word address into ProgramMemory (combinational read, same cycle).
//  Registers the returned word with its PC+4 for decode.
//  Handles stall, flush, branch/jump redirect, and a halt FSM stopping fetch on HALT_WORD.
// PARAMETERS
//  DATA_WIDTH  32            width of PC, instruction and target buses
//  PC_RESET    32'h00400000  PC value loaded on reset
//  NOP_WORD    32'h00000000  bubble written into IF/ID on flush
//  HALT_WORD   32'hFFFFFFFF  instruction encoding that halts fetch
// PORTS
//  clk             in   1           rising-edge clock
//  reset           in   1           asynchronous, active-high reset
//  Stall           in   1           hold PC and IF/ID (hazard unit)
//  Flush           in   1           load NOP_WORD into IF/ID, Valid=0
//  BranchTaken     in   1           redirect PC to BranchTarget
//  BranchTarget    in   DATA_WIDTH  branch destination byte address
//  JumpTaken       in   1           redirect PC to JumpTarget
//  JumpTarget      in   DATA_WIDTH  jump destination byte address
//  Instruction_i   in   DATA_WIDTH  word from ProgramMemory
//  PC_o            out  DATA_WIDTH  current PC -> ProgramMemory Address
//  IFID_Instr_o    out  DATA_WIDTH  registered instruction
//  IFID_PCPlus4_o  out  DATA_WIDTH  registered PC+4 of that instruction
//  IFID_Valid_o    out  1           IF/ID holds a real instruction
//  Halted_o        out  1           FSM in HALTED
//  FetchCount_o    out  32          instructions accepted into IF/ID
// BEHAVIOUR
//  Reset (async): PC_o=PC_RESET, IFID_Instr_o=NOP_WORD, IFID_PCPlus4_o=0,
//   IFID_Valid_o=0, Halted_o=0, FetchCount_o=0, state=BOOT.
//  FSM: BOOT -> RUN on first clk after reset release (no fetch in BOOT, PC held).
//   RUN -> HALTED when an IF/ID load (no Stall, no Flush) captures HALT_WORD.
//   HALTED -> RUN on BranchTaken|JumpTaken (speculative halt cancelled).
//  Next PC priority (RUN or HALTED): JumpTaken > BranchTaken > Stall hold >
//   HALTED hold > PC+4. Redirect overrides Stall.
//  Targets: bits [1:0] forced to 2'b00 before load. PC+4 wraps mod 2^DATA_WIDTH.
//  IF/ID update, RUN only: Flush -> NOP_WORD, Valid=0 (overrides Stall).
//   Else Stall -> hold all IF/ID fields. Else load Instruction_i, PC_o+4, Valid=1.
//  In BOOT and HALTED with no redirect: IF/ID = NOP_WORD, Valid=0.
//  Redirect cycle: the word fetched this cycle is wrong-path; the hazard unit
//   asserts Flush with the redirect. The block does not self-flush.
//  FetchCount_o: +1 on each IF/ID load with Valid=1. Wraps at 2^32.
//  Latency: PC_o to IFID_Instr_o is 1 clk. A redirect is visible on PC_o next clk.
//  Reset mid-operation: all state returns to reset values immediately (async).
// TESTING
//  Reset, 4 clks, mem[i]=i+1 -> BOOT 1 clk; IF/ID sees 1,2,3 with
//   PCPlus4 0x00400004/08/0C; FetchCount=3.
//  Stall for 2 clks at PC 0x00400008 -> PC_o and IF/ID frozen, FetchCount unchanged.
//   Resumes at 0x0040000C.
//  BranchTaken + Flush, BranchTarget=0x00400023 -> next PC_o=0x00400020,
//   IF/ID=NOP_WORD, Valid=0.
//  JumpTaken and BranchTaken same clk, Stall=1 -> PC_o=JumpTarget; IF/ID held.
//  HALT_WORD fetched -> Halted_o=1 next clk, PC frozen, Valid=0.
//   Then JumpTaken -> RUN, PC_o=JumpTarget.
//  reset pulsed mid-run between edges -> outputs at reset values before next clk.
//  PC=0xFFFFFFFC, no redirect -> PC_o wraps to 0x00000000.

Source files
------------

// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls, program-memory word and PC,
// and the IF/ID register contents handed to decode.
interface instruction_fetch_stage_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  stall;
    logic                  flush;
    logic                  branch_taken;
    logic [DATA_WIDTH-1:0] branch_target;
    logic                  jump_taken;
    logic [DATA_WIDTH-1:0] jump_target;
    logic [DATA_WIDTH-1:0] instruction;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] ifid_instr;
    logic [DATA_WIDTH-1:0] ifid_pcplus4;
    logic                  ifid_valid;
    logic                  halted;
    logic [31:0]           fetch_count;

    // Pipeline control and program memory side.
    modport master (
        output stall, flush, branch_taken, branch_target,
               jump_taken, jump_target, instruction,
        input  pc, ifid_instr, ifid_pcplus4, ifid_valid, halted, fetch_count
    );

    // The fetch stage itself.
    modport slave (
        input  stall, flush, branch_taken, branch_target,
               jump_taken, jump_target, instruction,
        output pc, ifid_instr, ifid_pcplus4, ifid_valid, halted, fetch_count
    );
endinterface

// File: rtl/instruction_fetch_stage.sv
// MIPS fetch stage: PC register, next-PC select, IF/ID register and a
// BOOT/RUN/HALTED controller that stops fetching once HALT_WORD is accepted.
module instruction_fetch_stage #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] PC_RESET   = 32'h0040_0000,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input logic                      clk,
    input logic                      reset,
    instruction_fetch_stage_if.slave bus
);
    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0] WORD_MASK = ~DATA_WIDTH'(3);

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] pc, pc_next, pc_plus4;
    logic [DATA_WIDTH-1:0] ifid_instr, ifid_instr_next;
    logic [DATA_WIDTH-1:0] ifid_pcplus4, ifid_pcplus4_next;
    logic                  ifid_valid, ifid_valid_next;
    logic [31:0]           fetch_count, fetch_count_next;
    logic                  redirect;

    assign pc_plus4 = pc + DATA_WIDTH'(4);
    assign redirect = bus.jump_taken | bus.branch_taken;

    always_comb begin
        // NOTE: every signal gets a hold value first so no path leaves it unassigned (no latches).
        state_next        = state;
        pc_next           = pc;
        ifid_instr_next   = ifid_instr;
        ifid_pcplus4_next = ifid_pcplus4;
        ifid_valid_next   = ifid_valid;
        fetch_count_next  = fetch_count;

        unique case (state)
            BOOT: begin
                state_next      = RUN;
                ifid_instr_next = NOP_WORD;
                ifid_valid_next = 1'b0;
            end
            RUN: begin
                pc_next = bus.stall ? pc : pc_plus4;
                if (bus.flush) begin
                    ifid_instr_next = NOP_WORD;
                    ifid_valid_next = 1'b0;
                end else if (!bus.stall) begin
                    ifid_instr_next   = bus.instruction;
                    ifid_pcplus4_next = pc_plus4;
                    ifid_valid_next   = 1'b1;
                    fetch_count_next  = fetch_count + 32'd1;
                    if (bus.instruction == HALT_WORD) state_next = HALTED;
                end
            end
            HALTED: begin
                ifid_instr_next = NOP_WORD;
                ifid_valid_next = 1'b0;
                if (redirect) state_next = RUN;
            end
            default: state_next = BOOT;
        endcase

        // Redirects win over stall and halt; the PC is not touched while booting.
        if (state != BOOT) begin
            if (bus.jump_taken)        pc_next = bus.jump_target & WORD_MASK;
            else if (bus.branch_taken) pc_next = bus.branch_target & WORD_MASK;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= BOOT;
            pc           <= PC_RESET;
            ifid_instr   <= NOP_WORD;
            ifid_pcplus4 <= '0;
            ifid_valid   <= 1'b0;
            fetch_count  <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state        <= state_next;
            pc           <= pc_next;
            ifid_instr   <= ifid_instr_next;
            ifid_pcplus4 <= ifid_pcplus4_next;
            ifid_valid   <= ifid_valid_next;
            fetch_count  <= fetch_count_next;
        end
    end

    assign bus.pc           = pc;
    assign bus.ifid_instr   = ifid_instr;
    assign bus.ifid_pcplus4 = ifid_pcplus4;
    assign bus.ifid_valid   = ifid_valid;
    assign bus.halted       = (state == HALTED);
    assign bus.fetch_count  = fetch_count;
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed scenarios plus random control
// traffic checked against a cycle-level behavioural model of the stage.
module tb_instruction_fetch_stage;
    localparam logic [31:0] PC_RESET = 32'h0040_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [31:0] HALT     = 32'hFFFF_FFFF;

    logic        clk;
    logic        reset;
    logic [31:0] halt_addr;
    int          n_checks;
    int          n_pass;

    // Behavioural model of the fetch stage.
    bit          m_booted;
    bit          m_halted;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcplus4;
    logic        m_valid;
    logic [31:0] m_count;

    instruction_fetch_stage_if #(.DATA_WIDTH(32)) bus();

    instruction_fetch_stage #(
        .DATA_WIDTH(32),
        .PC_RESET  (PC_RESET),
        .NOP_WORD  (NOP),
        .HALT_WORD (HALT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Program memory: word i holds i+1, except one optional HALT location.
    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] h);
        if (a == h) return HALT;
        return ((a - PC_RESET) >> 2) + 32'd1;
    endfunction

    assign bus.instruction = mem_word(bus.pc, halt_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_booted  = 1'b0;
        m_halted  = 1'b0;
        m_pc      = PC_RESET;
        m_instr   = NOP;
        m_pcplus4 = 32'd0;
        m_valid   = 1'b0;
        m_count   = 32'd0;
    endtask

    task automatic model_step(input logic s, input logic f, input logic b, input logic [31:0] bt,
                              input logic j, input logic [31:0] jt);
        logic [31:0] npc;
        logic [31:0] word;
        if (!m_booted) begin
            m_booted = 1'b1;
            m_instr  = NOP;
            m_valid  = 1'b0;
            return;
        end
        npc = (s || m_halted) ? m_pc : m_pc + 32'd4;
        if (b) npc = bt & ~32'd3;
        if (j) npc = jt & ~32'd3;
        if (m_halted) begin
            m_instr = NOP;
            m_valid = 1'b0;
            if (b || j) m_halted = 1'b0;
        end else if (f) begin
            m_instr = NOP;
            m_valid = 1'b0;
        end else if (!s) begin
            word      = mem_word(m_pc, halt_addr);
            m_instr   = word;
            m_pcplus4 = m_pc + 32'd4;
            m_valid   = 1'b1;
            m_count   = m_count + 32'd1;
            if (word == HALT) m_halted = 1'b1;
        end
        m_pc = npc;
    endtask

    // Drive one cycle of inputs, advance the model, and sample 1 time unit after the edge.
    task automatic step(input logic s, input logic f, input logic b, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt);
        bus.stall         = s;
        bus.flush         = f;
        bus.branch_taken  = b;
        bus.branch_target = bt;
        bus.jump_taken    = j;
        bus.jump_target   = jt;
        model_step(s, f, b, bt, j, jt);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset             = 1'b1;
        bus.stall         = 1'b0;
        bus.flush         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'd0;
        bus.jump_taken    = 1'b0;
        bus.jump_target   = 32'd0;
        #3;
        n_checks++; if (bus.pc !== PC_RESET) $display("FAIL reset_pc: got %h expected %h", bus.pc, PC_RESET); else n_pass++;
        n_checks++; if (bus.ifid_instr !== NOP) $display("FAIL reset_instr: got %h expected %h", bus.ifid_instr, NOP); else n_pass++;
        n_checks++; if (bus.ifid_pcplus4 !== 32'd0) $display("FAIL reset_pcplus4: got %h expected 0", bus.ifid_pcplus4); else n_pass++;
        n_checks++; if (bus.ifid_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.ifid_valid); else n_pass++;
        n_checks++; if (bus.halted !== 1'b0) $display("FAIL reset_halted: got %b expected 0", bus.halted); else n_pass++;
        n_checks++; if (bus.fetch_count !== 32'd0) $display("FAIL reset_count: got %0d expected 0", bus.fetch_count); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_sequential();
        idle();
        n_checks++; if (bus.pc !== PC_RESET) $display("FAIL boot_pc: got %h expected %h", bus.pc, PC_RESET); else n_pass++;
        n_checks++; if (bus.ifid_valid !== 1'b0) $display("FAIL boot_valid: got %b expected 0", bus.ifid_valid); else n_pass++;
        for (int k = 1; k <= 3; k++) begin
            idle();
            n_checks++; if (bus.ifid_instr !== 32'(k)) $display("FAIL seq_instr%0d: got %h expected %h", k, bus.ifid_instr, 32'(k)); else n_pass++;
            n_checks++; if (bus.ifid_pcplus4 !== PC_RESET + 32'(4 * k)) $display("FAIL seq_pcplus4_%0d: got %h expected %h", k, bus.ifid_pcplus4, PC_RESET + 32'(4 * k)); else n_pass++;
            n_checks++; if (bus.ifid_valid !== 1'b1) $display("FAIL seq_valid%0d: got %b expected 1", k, bus.ifid_valid); else n_pass++;
        end
        n_checks++; if (bus.fetch_count !== 32'd3) $display("FAIL seq_count: got %0d expected 3", bus.fetch_count); else n_pass++;
    endtask

    task automatic test_stall();
        do_reset();
        repeat (3) idle();
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
            n_checks++; if (bus.pc !== 32'h0040_0008) $display("FAIL stall_pc%0d: got %h expected 00400008", k, bus.pc); else n_pass++;
            n_checks++; if (bus.ifid_instr !== 32'd2) $display("FAIL stall_instr%0d: got %h expected 2", k, bus.ifid_instr); else n_pass++;
            n_checks++; if (bus.fetch_count !== 32'd2) $display("FAIL stall_count%0d: got %0d expected 2", k, bus.fetch_count); else n_pass++;
        end
        idle();
        n_checks++; if (bus.pc !== 32'h0040_000C) $display("FAIL resume_pc: got %h expected 0040000c", bus.pc); else n_pass++;
        n_checks++; if (bus.ifid_instr !== 32'd3) $display("FAIL resume_instr: got %h expected 3", bus.ifid_instr); else n_pass++;
        n_checks++; if (bus.ifid_pcplus4 !== 32'h0040_000C) $display("FAIL resume_pcplus4: got %h expected 0040000c", bus.ifid_pcplus4); else n_pass++;
    endtask

    task automatic test_branch();
        step(1'b0, 1'b1, 1'b1, 32'h0040_0023, 1'b0, 32'd0);
        n_checks++; if (bus.pc !== 32'h0040_0020) $display("FAIL branch_pc: got %h expected 00400020", bus.pc); else n_pass++;
        n_checks++; if (bus.ifid_instr !== NOP) $display("FAIL branch_instr: got %h expected %h", bus.ifid_instr, NOP); else n_pass++;
        n_checks++; if (bus.ifid_valid !== 1'b0) $display("FAIL branch_valid: got %b expected 0", bus.ifid_valid); else n_pass++;
        idle();
        n_checks++; if (bus.ifid_instr !== 32'd9) $display("FAIL branch_fetch: got %h expected 9", bus.ifid_instr); else n_pass++;
        n_checks++; if (bus.ifid_pcplus4 !== 32'h0040_0024) $display("FAIL branch_pcplus4: got %h expected 00400024", bus.ifid_pcplus4); else n_pass++;
    endtask

    task automatic test_jump_priority();
        logic [31:0] held_instr;
        logic [31:0] held_count;
        held_instr = m_instr;
        held_count = m_count;
        step(1'b1, 1'b0, 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0202);
        n_checks++; if (bus.pc !== 32'h0040_0200) $display("FAIL jump_pc: got %h expected 00400200", bus.pc); else n_pass++;
        n_checks++; if (bus.ifid_instr !== held_instr) $display("FAIL jump_held_instr: got %h expected %h", bus.ifid_instr, held_instr); else n_pass++;
        n_checks++; if (bus.ifid_valid !== 1'b1) $display("FAIL jump_held_valid: got %b expected 1", bus.ifid_valid); else n_pass++;
        n_checks++; if (bus.fetch_count !== held_count) $display("FAIL jump_held_count: got %0d expected %0d", bus.fetch_count, held_count); else n_pass++;
    endtask

    task automatic test_halt();
        step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h0040_0300);
        halt_addr = 32'h0040_0304;
        idle();
        idle();
        n_checks++; if (bus.ifid_instr !== HALT) $display("FAIL halt_instr: got %h expected %h", bus.ifid_instr, HALT); else n_pass++;
        n_checks++; if (bus.halted !== 1'b1) $display("FAIL halt_flag: got %b expected 1", bus.halted); else n_pass++;
        n_checks++; if (bus.pc !== 32'h0040_0308) $display("FAIL halt_pc: got %h expected 00400308", bus.pc); else n_pass++;
        n_checks++; if (bus.fetch_count !== m_count) $display("FAIL halt_count: got %0d expected %0d", bus.fetch_count, m_count); else n_pass++;
        for (int k = 0; k < 2; k++) begin
            idle();
            n_checks++; if (bus.halted !== 1'b1) $display("FAIL halted_flag%0d: got %b expected 1", k, bus.halted); else n_pass++;
            n_checks++; if (bus.pc !== 32'h0040_0308) $display("FAIL halted_pc%0d: got %h expected 00400308", k, bus.pc); else n_pass++;
            n_checks++; if (bus.ifid_valid !== 1'b0) $display("FAIL halted_valid%0d: got %b expected 0", k, bus.ifid_valid); else n_pass++;
            n_checks++; if (bus.ifid_instr !== NOP) $display("FAIL halted_instr%0d: got %h expected %h", k, bus.ifid_instr, NOP); else n_pass++;
        end
        step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h0040_0400);
        halt_addr = 32'h0000_0001;
        n_checks++; if (bus.halted !== 1'b0) $display("FAIL unhalt_flag: got %b expected 0", bus.halted); else n_pass++;
        n_checks++; if (bus.pc !== 32'h0040_0400) $display("FAIL unhalt_pc: got %h expected 00400400", bus.pc); else n_pass++;
        idle();
        n_checks++; if (bus.ifid_instr !== mem_word(32'h0040_0400, halt_addr)) $display("FAIL unhalt_fetch: got %h expected %h", bus.ifid_instr, mem_word(32'h0040_0400, halt_addr)); else n_pass++;
    endtask

    task automatic test_wrap();
        step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC);
        n_checks++; if (bus.pc !== 32'hFFFF_FFFC) $display("FAIL wrap_top_pc: got %h expected fffffffc", bus.pc); else n_pass++;
        idle();
        n_checks++; if (bus.pc !== 32'h0000_0000) $display("FAIL wrap_pc: got %h expected 00000000", bus.pc); else n_pass++;
        n_checks++; if (bus.ifid_pcplus4 !== 32'h0000_0000) $display("FAIL wrap_pcplus4: got %h expected 00000000", bus.ifid_pcplus4); else n_pass++;
    endtask

    task automatic test_async_reset();
        repeat (2) idle();
        #2 reset = 1'b1;
        #1;
        n_checks++; if (bus.pc !== PC_RESET) $display("FAIL areset_pc: got %h expected %h", bus.pc, PC_RESET); else n_pass++;
        n_checks++; if (bus.ifid_valid !== 1'b0) $display("FAIL areset_valid: got %b expected 0", bus.ifid_valid); else n_pass++;
        n_checks++; if (bus.ifid_instr !== NOP) $display("FAIL areset_instr: got %h expected %h", bus.ifid_instr, NOP); else n_pass++;
        n_checks++; if (bus.fetch_count !== 32'd0) $display("FAIL areset_count: got %0d expected 0", bus.fetch_count); else n_pass++;
        n_checks++; if (bus.halted !== 1'b0) $display("FAIL areset_halted: got %b expected 0", bus.halted); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        logic s, f, b, j;
        logic [31:0] bt, jt;
        for (int n = 0; n < 400; n++) begin
            s  = ($urandom_range(0, 3) == 0);
            f  = ($urandom_range(0, 6) == 0);
            b  = ($urandom_range(0, 9) == 0);
            j  = ($urandom_range(0, 11) == 0);
            bt = PC_RESET + 32'($urandom_range(0, 4095));
            jt = $urandom();
            step(s, f, b, bt, j, jt);
            n_checks++; if (bus.pc !== m_pc) $display("FAIL rand_pc@%0d: got %h expected %h", n, bus.pc, m_pc); else n_pass++;
            n_checks++; if (bus.ifid_instr !== m_instr) $display("FAIL rand_instr@%0d: got %h expected %h", n, bus.ifid_instr, m_instr); else n_pass++;
            n_checks++; if (bus.ifid_valid !== m_valid) $display("FAIL rand_valid@%0d: got %b expected %b", n, bus.ifid_valid, m_valid); else n_pass++;
            n_checks++; if (bus.halted !== m_halted) $display("FAIL rand_halted@%0d: got %b expected %b", n, bus.halted, m_halted); else n_pass++;
            n_checks++; if (bus.fetch_count !== m_count) $display("FAIL rand_count@%0d: got %0d expected %0d", n, bus.fetch_count, m_count); else n_pass++;
            if (m_valid) begin
                n_checks++; if (bus.ifid_pcplus4 !== m_pcplus4) $display("FAIL rand_pcplus4@%0d: got %h expected %h", n, bus.ifid_pcplus4, m_pcplus4); else n_pass++;
            end
        end
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        halt_addr = 32'h0000_0001;
        model_reset();
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_jump_priority();
        test_halt();
        test_wrap();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
